// File: rtl/neopixel_top.sv
// WS2812 strip driver: frame timer, animated GRB pattern, NRZ serialiser, heartbeat.
// Ports: clock_125m/resetn (async low), neopixel_drive (serial data), leds (heartbeat).
module neopixel_top #(
   parameter int C_SIM_MODE     = 0,
   parameter int C_CONTROL_RATE = 60,
   parameter int C_PIXEL_COUNT  = 16
) (
   input  logic clock_125m,
   input  logic resetn,
   output logic neopixel_drive,
   output logic leds
);
   localparam int P       = 125_000_000 / C_CONTROL_RATE;
   localparam int TW      = (P > 1) ? $clog2(P) : 1;
   localparam int LAT     = (C_SIM_MODE != 0) ? 625 : 6250;
   localparam int HB_HALF = C_CONTROL_RATE / 2;
   localparam int HB_DIV  = (C_SIM_MODE != 0) ? 1 :
                            ((HB_HALF < 1) ? 1 : HB_HALF);
   localparam int HW      = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

   localparam logic [TW-1:0] P_LAST   = TW'(P - 1);
   localparam logic [12:0]   LAT_LAST = 13'(LAT - 1);
   localparam logic [8:0]    PIX_LAST = 9'(C_PIXEL_COUNT - 1);
   localparam logic [HW-1:0] HB_LAST  = HW'(HB_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    state_q, state_d;
   logic [12:0]   cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [8:0]    pix_q, pix_d;
   logic [7:0]    fc_q, fc_d;
   logic [HW-1:0] hb_q, hb_d;
   logic          leds_q, leds_d;
   logic          drive_q, drive_d;

   logic          tick;
   logic          frame_end;
   logic [7:0]    pix_c;
   logic [7:0]    cur_byte;
   logic          cur_bit;
   logic [12:0]   hi_last;
   logic [12:0]   lo_last;
   logic          last_bit;

   always_comb begin
      tick    = (timer_q == P_LAST);
      timer_d = tick ? '0 : timer_q + TW'(1);

      // Only the low 4 pixel bits matter: 16*i wraps mod 256.
      pix_c = fc_q + {pix_q[3:0], 4'b0000};
      case (bit_q[4:3])
         2'd0:    cur_byte = pix_c;
         2'd1:    cur_byte = ~pix_c;
         default: cur_byte = 8'h00;
      endcase
      cur_bit  = cur_byte[3'd7 - bit_q[2:0]];
      hi_last  = cur_bit ? 13'd99 : 13'd49;
      lo_last  = cur_bit ? 13'd55 : 13'd105;
      last_bit = (bit_q == 5'd23) && (pix_q == PIX_LAST);

      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      pix_d     = pix_q;
      fc_d      = fc_q;
      frame_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Ticks outside IDLE are simply ignored.
            if (tick) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               bit_d   = '0;
               pix_d   = '0;
            end
         end
         ST_HIGH: begin
            if (cnt_q == hi_last) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         ST_LOW: begin
            if (cnt_q == lo_last) begin
               cnt_d = '0;
               if (last_bit) begin
                  state_d = ST_LATCH;
               end else begin
                  state_d = ST_HIGH;
                  if (bit_q == 5'd23) begin
                     bit_d = '0;
                     pix_d = pix_q + 9'd1;
                  end else begin
                     bit_d = bit_q + 5'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         default: begin
            if (cnt_q == LAT_LAST) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               fc_d      = fc_q + 8'd1;
               frame_end = 1'b1;
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
      endcase

      hb_d   = hb_q;
      leds_d = leds_q;
      if (frame_end) begin
         if (hb_q == HB_LAST) begin
            hb_d   = '0;
            leds_d = ~leds_q;
         end else begin
            hb_d = hb_q + HW'(1);
         end
      end

      // Registered from next state so the pin is a single clean flop.
      drive_d = (state_d == ST_HIGH);
   end

   always_ff @(posedge clock_125m or negedge resetn) begin
      if (!resetn) begin
         timer_q <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         pix_q   <= '0;
         fc_q    <= '0;
         hb_q    <= '0;
         leds_q  <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         pix_q   <= pix_d;
         fc_q    <= fc_d;
         hb_q    <= hb_d;
         leds_q  <= leds_d;
         drive_q <= drive_d;
      end
   end

   assign neopixel_drive = drive_q;
   assign leds           = leds_q;

endmodule

// File: tb/tb_neopixel_top.sv
// Bench for neopixel_top: timing-level reference model plus pinned waveform checks.
// Two instances: N=4 (frames fit the period) and N=8 (every second tick dropped).
module tb_neopixel_top;
   localparam int P   = 15625;
   localparam int LAT = 625;
   localparam int NA  = 4;
   localparam int NB  = 8;

   logic clk = 1'b0;
   logic rstn_a = 1'b0;
   logic rstn_b = 1'b0;
   logic drv_a, led_a, drv_b, led_b;
   int   cyc_a, cyc_b;
   int   checks = 0;
   int   errors = 0;
   int   rise_a[$], wid_a[$], rise_b[$], wid_b[$];

   neopixel_top #(.C_SIM_MODE(1), .C_CONTROL_RATE(8000), .C_PIXEL_COUNT(NA)) u_a (
      .clock_125m(clk), .resetn(rstn_a), .neopixel_drive(drv_a), .leds(led_a));
   neopixel_top #(.C_SIM_MODE(1), .C_CONTROL_RATE(8000), .C_PIXEL_COUNT(NB)) u_b (
      .clock_125m(clk), .resetn(rstn_b), .neopixel_drive(drv_b), .leds(led_b));

   always #4 clk = ~clk;

   // Cycle index = rising edges since reset release.
   always @(posedge clk or negedge rstn_a)
      if (!rstn_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
   always @(posedge clk or negedge rstn_b)
      if (!rstn_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame j starts at the first multiple of P whose tick (one cycle
   // earlier) finds the previous frame fully finished.
   function automatic void model(input int c, input int n,
                                 output logic d, output logic l);
      int f, s, ns, j, done, t, bi, p, b, cv, by, th;
      f = 156 * 24 * n + LAT;
      d = 1'b0;
      l = 1'b0;
      if (c < P) return;
      s = P; j = 0; done = 0;
      while (1) begin
         if (s + f <= c) done++;
         ns = ((s + f + 1 + P - 1) / P) * P;
         if (ns > c) break;
         s = ns;
         j++;
      end
      l = done[0];
      t = c - s;
      if (t < 156 * 24 * n) begin
         bi = t / 156;
         p  = bi / 24;
         b  = bi % 24;
         cv = (j + 16 * p) % 256;
         by = (b < 8) ? cv : ((b < 16) ? 255 - cv : 0);
         th = ((by >> (7 - b % 8)) & 1) ? 100 : 50;
         d  = (t % 156) < th;
      end
   endfunction

   initial begin
      logic ed, el;
      forever begin
         @(negedge clk);
         model(cyc_a, NA, ed, el);
         chk("drive_a", drv_a, ed);
         chk("leds_a", led_a, el);
         model(cyc_b, NB, ed, el);
         chk("drive_b", drv_b, ed);
         chk("leds_b", led_b, el);
      end
   end

   initial begin
      logic pa, pb;
      int ra, rb;
      pa = 0; pb = 0; ra = 0; rb = 0;
      forever begin
         @(negedge clk);
         if (!rstn_a) begin
            rise_a.delete(); wid_a.delete(); pa = 0;
         end else begin
            if (drv_a && !pa) begin rise_a.push_back(cyc_a); ra = cyc_a; end
            if (!drv_a && pa) wid_a.push_back(cyc_a - ra);
            pa = drv_a;
         end
         if (!rstn_b) begin
            rise_b.delete(); wid_b.delete(); pb = 0;
         end else begin
            if (drv_b && !pb) begin rise_b.push_back(cyc_b); rb = cyc_b; end
            if (!drv_b && pb) wid_b.push_back(cyc_b - rb);
            pb = drv_b;
         end
      end
   end

   function automatic int px0_w(input int i);
      return (i >= 8 && i < 16) ? 100 : 50;
   endfunction

   // fc=1: G=0x01, R=0xFE.
   function automatic int f1_w(input int i);
      if (i < 7) return 50;
      if (i < 15) return 100;
      return 50;
   endfunction

   initial begin
      int g3[8];
      int tgt;
      g3 = '{50, 50, 100, 100, 50, 50, 50, 50};
      repeat (10) begin
         @(negedge clk);
         chk("rst_drive_a", drv_a, 0);
         chk("rst_leds_a", led_a, 0);
      end
      rstn_a = 1'b1;
      rstn_b = 1'b1;

      while (cyc_a < 35100) @(negedge clk);
      chk("a_rise_count", (rise_a.size() >= 97 && wid_a.size() >= 112) ? 1 : 0, 1);
      if (rise_a.size() >= 97 && wid_a.size() >= 112) begin
         chk("first_rise", rise_a[0], P);
         for (int i = 0; i < 95; i++)
            chk("cell_period", rise_a[i+1] - rise_a[i], 156);
         chk("frame_spacing", rise_a[96] - rise_a[0], P);
         chk("latch_gap", (rise_a[96] - (rise_a[95] + wid_a[95]) >= LAT) ? 1 : 0, 1);
         for (int i = 0; i < 24; i++) chk("f0_px0", wid_a[i], px0_w(i));
         for (int i = 0; i < 8; i++) chk("f0_px3_g", wid_a[72+i], g3[i]);
         for (int i = 0; i < 16; i++) chk("f1_px0", wid_a[96+i], f1_w(i));
      end
      chk("leds_after_f0", led_a, 1);

      tgt = 2 * P + 40 * 156 + int'($urandom_range(5, 150));
      while (cyc_a < tgt) @(negedge clk);
      #($urandom_range(1, 3));
      rstn_a = 1'b0;
      #1;
      chk("async_rst_drive", drv_a, 0);
      chk("async_rst_leds", led_a, 0);
      repeat ($urandom_range(3, 12)) @(negedge clk);
      rstn_a = 1'b1;

      while (cyc_a < P + 24 * 156 + 200) @(negedge clk);
      chk("a2_rise_count", (rise_a.size() >= 24 && wid_a.size() >= 24) ? 1 : 0, 1);
      if (rise_a.size() >= 24 && wid_a.size() >= 24) begin
         chk("rst_first_rise", rise_a[0], P);
         for (int i = 0; i < 24; i++) chk("rst_f0_px0", wid_a[i], px0_w(i));
      end

      chk("b_rise_count", (rise_b.size() >= 208 && wid_b.size() >= 208) ? 1 : 0, 1);
      if (rise_b.size() >= 208 && wid_b.size() >= 208) begin
         chk("b_first_rise", rise_b[0], P);
         chk("b_frame_spacing", rise_b[192] - rise_b[0], 2 * P);
         for (int i = 0; i < 16; i++) chk("b_f1_px0", wid_b[192+i], f1_w(i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
